ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// Purpose : queues read/write commands and issues them one at a time as single
//           non-pipelined AHB transfers (address phase, data phase, idle gap).
// Latency : rsp_valid three cycles after the push edge with a zero-wait slave.
// Backpr. : cmd_ready = !full; no bypass. m_hready=0 stalls ADDR/DATA indefinitely.
//
// Ports   : hclk/hrst (async active-high); cmd_* push side; rsp_* one-cycle
//           completion (rdata, err, mismatch); mis_cnt; busy; m_h* AHB master.
// Option  : define AHB_CMD_MASTER_CMP_EN to compare read data against the command
//           data and count mismatches. Without it rsp_mismatch/mis_cnt are tied
//           to 0 and command data only ever serves as write data.

// Generic synchronous FIFO: show-ahead read port, DEPTH must be a power of 2.
// Latency: pushed data visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module ahb_cmd_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             hclk,
    input  logic             hrst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module ahb_cmd_master #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int CMD_DEPTH = 4
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_mismatch,
    output logic [15:0]   mis_cnt,
    output logic          busy,
    output logic          m_hsel,
    output logic [AW-1:0] m_haddr,
    output logic [1:0]    m_htrans,
    output logic          m_hwrite,
    output logic [2:0]    m_hsize,
    output logic [3:0]    m_hprot,
    output logic [DW-1:0] m_hwdata,
    input  logic [DW-1:0] m_hrdata,
    input  logic          m_hready,
    input  logic [1:0]    m_hresp
);
    localparam int            BL       = $clog2(DW/8);
    localparam int            FW       = 1 + AW + DW;
    localparam logic [AW-1:0] LOW_MASK = AW'((1 << BL) - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [FW-1:0] head;

    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] hwdata_q;
    logic          err_seen;
    logic          done;
    logic          err_now;

    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;

    // Held at 0 while in reset so the push side sees no room until release.
    assign cmd_ready = !fifo_full && !hrst;
    assign busy      = !fifo_empty || (state != IDLE);

    ahb_cmd_master_fifo #(
        .WIDTH (FW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .hclk     (hclk),
        .hrst     (hrst),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat ({cmd_write, cmd_addr, cmd_data}),
        .pop_vld  (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ADDR;
            ADDR:    if (m_hready)    state_nxt = DATA;
            DATA:    if (m_hready)    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        m_hsel   = 1'b0;
        m_htrans = 2'b00;
        m_hsize  = 3'b000;
        m_hprot  = 4'b0000;
        pop      = 1'b0;
        case (state)
            IDLE: pop = !fifo_empty;
            ADDR: begin
                m_hsel   = 1'b1;
                m_htrans = 2'b10;
                m_hsize  = 3'(BL);
                m_hprot  = 4'b0011;
            end
            default: ;
        endcase
    end

    // Command fields latch at the pop so address/write hold until the next pop.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (pop) begin
            write_q <= head[FW-1];
            addr_q  <= head[FW-2 -: AW];
            data_q  <= head[DW-1:0];
        end
    end

    assign m_hwrite = write_q;
    assign m_haddr  = addr_q & ~LOW_MASK;

    // Write data moves onto the bus only as the data phase opens; reads leave
    // the previous value on the bus.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst)                                    hwdata_q <= '0;
        else if (state == ADDR && m_hready && write_q) hwdata_q <= data_q;
    end
    assign m_hwdata = hwdata_q;

    // AHB ERROR is two cycles: first with hready=0, then with hready=1. The
    // first cycle is remembered so either cycle alone is enough to flag it.
    assign done    = (state == DATA) && m_hready;
    assign err_now = err_seen || (m_hresp == 2'b01);

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst)                                          err_seen <= 1'b0;
        else if (state == ADDR)                            err_seen <= 1'b0;
        else if (state == DATA && !m_hready && m_hresp == 2'b01) err_seen <= 1'b1;
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done;
            rsp_err_q   <= done && err_now;
            if (done) rsp_rdata_q <= write_q ? '0 : m_hrdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef AHB_CMD_MASTER_CMP_EN
    logic        mis_now;
    logic        rsp_mis_q;
    logic [15:0] mis_cnt_q;

    // For reads the command data is the expected value; writes and errored
    // reads never count as a mismatch.
    assign mis_now = done && !write_q && !err_now && (m_hrdata != data_q);

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            rsp_mis_q <= 1'b0;
            mis_cnt_q <= '0;
        end else begin
            rsp_mis_q <= mis_now;
            if (mis_now && mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign rsp_mismatch = rsp_mis_q;
    assign mis_cnt      = mis_cnt_q;
`else
    assign rsp_mismatch = 1'b0;
    assign mis_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Purpose : directed bench for ahb_cmd_master (32-bit instance plus a 64-bit one).
// Latency : n/a.
// Backpr. : bench acts as AHB slave, driving m_hready/m_hresp per vector.
module tb_ahb_cmd_master;
`ifdef AHB_CMD_MASTER_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hrst;
    always #5 hclk = ~hclk;

    // 32-bit instance
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_err, rsp_mismatch, busy;
    logic [31:0] rsp_rdata;
    logic [15:0] mis_cnt;
    logic        m_hsel, m_hwrite, m_hready;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_htrans, m_hresp;
    logic [2:0]  m_hsize;
    logic [3:0]  m_hprot;

    // 64-bit instance
    logic        cmd_valid_w, cmd_ready_w;
    logic [31:0] cmd_addr_w;
    logic [63:0] cmd_data_w;
    logic        rsp_valid_w, rsp_err_w, rsp_mismatch_w, busy_w;
    logic [63:0] rsp_rdata_w;
    logic [15:0] mis_cnt_w;
    logic        m_hsel_w, m_hwrite_w;
    logic [31:0] m_haddr_w;
    logic [63:0] m_hwdata_w;
    logic [1:0]  m_htrans_w;
    logic [2:0]  m_hsize_w;
    logic [3:0]  m_hprot_w;

    ahb_cmd_master #(.DW(32), .AW(32), .CMD_DEPTH(4)) u_dut (
        .hclk(hclk), .hrst(hrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_mismatch(rsp_mismatch), .mis_cnt(mis_cnt), .busy(busy),
        .m_hsel(m_hsel), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp)
    );

    ahb_cmd_master #(.DW(64), .AW(32), .CMD_DEPTH(2)) u_dut64 (
        .hclk(hclk), .hrst(hrst),
        .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w), .cmd_write(1'b0),
        .cmd_addr(cmd_addr_w), .cmd_data(cmd_data_w),
        .rsp_valid(rsp_valid_w), .rsp_rdata(rsp_rdata_w), .rsp_err(rsp_err_w),
        .rsp_mismatch(rsp_mismatch_w), .mis_cnt(mis_cnt_w), .busy(busy_w),
        .m_hsel(m_hsel_w), .m_haddr(m_haddr_w), .m_htrans(m_htrans_w), .m_hwrite(m_hwrite_w),
        .m_hsize(m_hsize_w), .m_hprot(m_hprot_w), .m_hwdata(m_hwdata_w),
        .m_hrdata(64'd0), .m_hready(1'b1), .m_hresp(2'b00)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;     // write data, or expected read data
        logic [31:0] srd;      // slave read data on final data cycle
        int          waits;    // hready=0 cycles before the final cycle
        bit          err;      // slave answers with two-cycle ERROR
        logic [31:0] e_haddr;
        logic [31:0] e_rdata;
        bit          e_err;
        bit          e_mis;
        logic [15:0] e_cnt;
        int          e_lat;
    } vec_t;

    vec_t vecs[7];

    // Pushes one command, plays the slave, and checks the response.
    // Latency counts cycles from the push edge to the rsp_valid edge.
    task automatic run_vec(input vec_t v, input string nm);
        int cyc  = 0;
        int dcnt = -1;
        bit got  = 1'b0;
        @(negedge hclk);
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_data = v.data;
        while (!got && cyc < 40) begin
            @(negedge hclk);
            cyc++;
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
                chk({nm, "_latency"},  64'(cyc - 1),     64'(v.e_lat));
                chk({nm, "_rdata"},    64'(rsp_rdata),   64'(v.e_rdata));
                chk({nm, "_err"},      64'(rsp_err),     64'(v.e_err));
                chk({nm, "_mismatch"}, 64'(rsp_mismatch), 64'(v.e_mis));
                chk({nm, "_mis_cnt"},  64'(mis_cnt),     64'(v.e_cnt));
            end else if (m_htrans == 2'b10) begin
                chk({nm, "_haddr"},  64'(m_haddr),  64'(v.e_haddr));
                chk({nm, "_hwrite"}, 64'(m_hwrite), 64'(v.wr));
                chk({nm, "_hsize"},  64'(m_hsize),  64'd2);
                chk({nm, "_hprot"},  64'(m_hprot),  64'h3);
                chk({nm, "_hsel"},   64'(m_hsel),   64'd1);
                m_hready = 1'b1; m_hresp = 2'b00;
                dcnt = 0;
            end else if (dcnt >= 0) begin
                if (dcnt < v.waits) begin
                    m_hready = 1'b0; m_hresp = 2'b00;
                end else if (v.err && dcnt == v.waits) begin
                    m_hready = 1'b0; m_hresp = 2'b01;
                end else begin
                    m_hready = 1'b1;
                    m_hresp  = v.err ? 2'b01 : 2'b00;
                    m_hrdata = v.srd;
                    if (v.wr) chk({nm, "_hwdata"}, 64'(m_hwdata), 64'(v.data));
                end
                dcnt++;
            end
        end
        if (!got) fail_now({nm, "_rsp"});
        m_hready = 1'b1; m_hresp = 2'b00; m_hrdata = '0;
        @(negedge hclk);
        chk({nm, "_pulse_end"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_busy_end"},  64'(busy),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hrst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        m_hready = 1'b1; m_hresp = 2'b00; m_hrdata = '0;
        cmd_valid_w = 1'b0; cmd_addr_w = '0; cmd_data_w = '0;

        //          wr addr        data          srd           w  e  e_haddr  e_rdata       ee em  e_cnt                 lat
        vecs[0] = '{1, 32'h0,  32'h5a5a5a5a, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 16'd0,                3};
        vecs[1] = '{0, 32'h0,  32'h5a5a5a5a, 32'h5a5a5a5a, 0, 0, 32'h0,  32'h5a5a5a5a, 0, 0, 16'd0,                3};
        vecs[2] = '{0, 32'h4,  32'hffff0000, 32'h0000ffff, 0, 0, 32'h4,  32'h0000ffff, 0, CMP, CMP ? 16'd1 : 16'd0, 3};
        vecs[3] = '{1, 32'h8,  32'h11223344, 32'h0,        3, 1, 32'h8,  32'h0,        1, 0, CMP ? 16'd1 : 16'd0, 7};
        vecs[4] = '{0, 32'hE,  32'h0,        32'hdeadbeef, 2, 0, 32'hC,  32'hdeadbeef, 0, CMP, CMP ? 16'd2 : 16'd0, 5};
        vecs[5] = '{0, 32'h10, 32'h12345678, 32'haaaa5555, 0, 1, 32'h10, 32'haaaa5555, 1, 0, CMP ? 16'd2 : 16'd0, 4};
        vecs[6] = '{1, 32'h23, 32'hcafef00d, 32'h0,        1, 0, 32'h20, 32'h0,        0, 0, CMP ? 16'd2 : 16'd0, 4};

        // ---- reset state: outputs low immediately, cmd_ready high after release
        #2 hrst = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_htrans",    64'(m_htrans),  64'd0);
        chk("rst_mis_cnt",   64'(mis_cnt),   64'd0);
        repeat (2) @(negedge hclk);
        hrst = 1'b0;
        #1;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // ---- table of single commands
        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // ---- back-to-back: one idle cycle between address phases
        begin
            int a0 = -1, a1 = -1, nr = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge hclk);
                if (c == 0) begin cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; end
                else if (c == 1) cmd_addr = 32'h44;
                else cmd_valid = 1'b0;
                if (m_htrans == 2'b10) begin
                    if (a0 < 0) a0 = c;
                    else if (a1 < 0) a1 = c;
                end
                if (rsp_valid) nr++;
            end
            chk("b2b_addr_gap",   64'(a1 - a0), 64'd3);
            chk("b2b_rsp_count",  64'(nr),      64'd2);
        end

        // ---- FIFO fill with slave stalled: one command sits in the address
        //      phase, CMD_DEPTH more queue behind it, then cmd_ready drops
        begin
            int acc = 0, nr = 0;
            m_hready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge hclk);
                if (acc < 5) begin
                    cmd_valid = 1'b1; cmd_write = 1'b0;
                    cmd_addr = 32'h100 + 32'(acc * 4); cmd_data = '0;
                    if (cmd_ready) acc++;
                end else cmd_valid = 1'b0;
            end
            @(negedge hclk);
            chk("fill_accepted",  64'(acc),       64'd5);
            chk("fill_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("fill_stuck_addr", 64'(m_haddr),  64'h100);
            m_hready = 1'b1;
            m_hrdata = m_haddr ^ 32'hC0DE0000;
            for (int c = 0; c < 60 && nr < 5; c++) begin
                @(negedge hclk);
                if (rsp_valid) begin
                    chk($sformatf("fill_order%0d", nr), 64'(rsp_rdata),
                        64'((32'h100 + 32'(nr * 4)) ^ 32'hC0DE0000));
                    nr++;
                end
                if (m_htrans == 2'b10) m_hrdata = m_haddr ^ 32'hC0DE0000;
            end
            chk("fill_rsp_count", 64'(nr), 64'd5);
            @(negedge hclk);
            chk("fill_busy_end", 64'(busy), 64'd0);
            m_hrdata = '0;
        end

        // ---- reset while stalled in the data phase with a command queued
        begin
            int nr = 0, na = 0;
            @(negedge hclk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200;
            @(negedge hclk);
            cmd_addr = 32'h204;
            @(negedge hclk);
            cmd_valid = 1'b0;
            m_hready = 1'b0;
            @(negedge hclk);
            chk("ar_pre_busy", 64'(busy), 64'd1);
            hrst = 1'b1;
            #1;
            chk("ar_htrans",    64'(m_htrans),  64'd0);
            chk("ar_busy",      64'(busy),      64'd0);
            chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("ar_haddr",     64'(m_haddr),   64'd0);
            @(negedge hclk);
            hrst = 1'b0;
            m_hready = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge hclk);
                if (rsp_valid) nr++;
                if (m_htrans == 2'b10) na++;
            end
            chk("ar_no_rsp",     64'(nr),        64'd0);
            chk("ar_no_addr",    64'(na),        64'd0);
            chk("ar_busy_after", 64'(busy),      64'd0);
            chk("ar_cmd_ready",  64'(cmd_ready), 64'd1);
            chk("ar_mis_cnt",    64'(mis_cnt),   64'd0);
        end

        // ---- 64-bit instance: address alignment and transfer size
        begin
            bit seen = 1'b0, got = 1'b0;
            @(negedge hclk);
            cmd_valid_w = 1'b1; cmd_addr_w = 32'h1C; cmd_data_w = 64'h0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge hclk);
                cmd_valid_w = 1'b0;
                if (m_htrans_w == 2'b10) begin
                    seen = 1'b1;
                    chk("w64_haddr", 64'(m_haddr_w), 64'h18);
                    chk("w64_hsize", 64'(m_hsize_w), 64'd3);
                end
                if (rsp_valid_w) got = 1'b1;
            end
            if (!seen) fail_now("w64_addr_phase");
            if (!got)  fail_now("w64_rsp");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
